// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encodings and default datapath width.
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin built from two half-subtractors and an OR.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;
    assign d1   = x ^ y;
    assign b1   = ~x & y;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - b_in, LSB first, one full-subtractor slice.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic br_q, br_d, bout_q, bout_d;
    logic d, bo, last;
    full_subtractor u_fs (.x(sa_q[0]), .y(sb_q[0]), .bin(br_q), .d(d), .bout(bo));
    assign last = cnt_q == LAST;
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: if (start) begin
                sa_d    = a;
                sb_d    = b;
                br_d    = b_in;
                sd_d    = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = {d, sd_q[WIDTH-1:1]};
                br_d  = bo;
                // hold on the last bit so the counter never wraps
                cnt_d = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    diff_d  = {d, sd_q[WIDTH-1:1]};
                    bout_d  = bo;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end
    assign busy  = state_q == ST_RUN;
    assign done  = state_q == ST_DONE;
    assign diff  = diff_q;
    assign b_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, hand-written and random checks against an arithmetic model.
module tb_serial_subtractor;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, b_in = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, b_out;
    logic [7:0] diff;
    int checks = 0, errors = 0;
    logic [7:0] exp_d = '0;
    logic exp_b = 1'b0;

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;
    vec_t vecs[6];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
        .busy(busy), .done(done), .diff(diff), .b_out(b_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - 9'(bi);
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                          input string nm, input logic [7:0] want_d, input logic want_b);
        int n;
        a = ta; b = tbv; b_in = tbin; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
        check({nm, " busy"}, busy, 1);
        n = 0;
        while (!done && n < 30) begin
            if (n == 4) check({nm, " hold diff"}, {23'd0, b_out, diff}, {23'd0, exp_b, exp_d});
            tick();
            n++;
        end
        check({nm, " latency"}, n, 8);
        check({nm, " diff"}, diff, want_d);
        check({nm, " b_out"}, b_out, want_b);
        exp_d = want_d; exp_b = want_b;
        tick();
        check({nm, " done pulse"}, done, 0);
    endtask

    initial begin
        int k, dones;
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic rbi;
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
        vecs[5] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0};
        tick(); tick();
        start = 1'b1;
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset diff", diff, 0);
        check("reset b_out", b_out, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle busy", busy, 0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), vecs[i].d, vecs[i].bo);

        // result hold: previous 0x05 must stay visible during the next run
        run_op(8'h01, 8'h02, 1'b0, "hold", 8'hFF, 1'b1);

        // start held across the whole op, operands change mid-run
        a = 8'h10; b = 8'h01; b_in = 1'b0; start = 1'b1;
        tick();
        dones = 0;
        for (k = 1; k <= 10; k++) begin
            if (k == 3) begin a = 8'hAA; b = 8'h55; end
            tick();
            if (done) begin
                dones++;
                check("busy-start diff", diff, 8'h0F);
                check("busy-start b_out", b_out, 0);
                check("busy-start done edge", k, 8);
            end
            if (k == 9) check("busy-start idle gap", busy, 0);
            if (k == 10) check("busy-start reaccept", busy, 1);
        end
        check("busy-start single done", dones, 1);
        start = 1'b0;
        k = 10;
        while (!done && k < 40) begin tick(); k++; end
        check("reaccept latency", k, 18);
        check("reaccept diff", diff, 8'h55);
        tick();

        // reset mid-operation
        a = 8'h40; b = 8'h20; b_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst diff", diff, 0);
        check("midrst b_out", b_out, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (done) dones++; end
        check("midrst no done", dones, 0);
        exp_d = '0; exp_b = 1'b0;
        run_op(8'h40, 8'h20, 1'b0, "post-rst", 8'h20, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
            r = model(ra, rb, rbi);
            run_op(ra, rb, rbi, $sformatf("rand%0d", i), r[7:0], r[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
